instr_mem_responder: RTL

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: loads a program from a streaming loader,
// then serves combinational fetches to a core, stalling it on a halt word
// and restarting it from address 0 on a start pulse.
module instr_mem_responder #(
  parameter int              DEPTH   = 256,
  parameter int              IW      = 9,
  parameter logic [IW-1:0]   HALT_OP = 9'h1FF,
  parameter logic [IW-1:0]   NOP_OP  = 9'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [IW-1:0]     load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic [15:0]       core,
  output logic [IW-1:0]     instr,
  output logic              cpu_rst,
  output logic              halt,
  output logic              addr_err,
  output logic [$clog2(DEPTH):0] load_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     load_count_q;
  logic            rst_pulse_q;
  logic            accept;
  logic            start_accept;
  logic            in_range;
  logic [IW-1:0]   rd_word;

  // NOTE: the array is not reset; its contents must survive reset so a
  // restarted program sees the last loaded image. It starts out holding
  // NOP_OP so unwritten locations fetch as no-ops.
  logic [IW-1:0]   mem [DEPTH] = '{default: NOP_OP};

  // Fetch path: any address above the array reads as a no-op.
  always_comb begin
    in_range = (core[15:AW] == '0);
    rd_word  = mem[core[AW-1:0]];
    instr    = in_range ? rd_word : NOP_OP;
  end

  // Next-state and handshake decode; defaults first so nothing latches.
  always_comb begin
    state_d      = state_q;
    load_ready   = 1'b0;
    accept       = 1'b0;
    start_accept = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          accept = 1'b1;
          // The final array slot is an implicit last word.
          if (load_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Start is ignored here, including when it coincides with a halt word.
        if (instr == HALT_OP) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (start) begin
          state_d      = RUN;
          start_accept = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Core-facing status: halt is combinational so the fetch stage stalls in
  // the same cycle the halt word is on instr.
  always_comb begin
    halt     = (state_q == HALTED) || ((state_q == RUN) && (instr == HALT_OP));
    addr_err = (state_q == RUN) && !in_range;
    cpu_rst  = (state_q == LOAD) || rst_pulse_q;
  end

  assign load_count = load_count_q;

  // Control state: FSM, write pointer, saturating load counter, restart pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      rst_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_pulse_q <= start_accept;
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (load_count_q != (AW + 1)'(DEPTH)) begin
          load_count_q <= load_count_q + 1'b1;
        end
      end
    end
  end

  // Program store write port; reset blocks a write offered in the same cycle.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

endmodule
